// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, full byte-enable
// constant, requester IDs and the byte-lane merge used by partial writes.
package dmem_arbiter_pkg;

  typedef enum logic [0:0] {
    DMEM_ARB_IDLE   = 1'b0,
    DMEM_ARB_RMW_WR = 1'b1
  } state_e;

  localparam logic [3:0] DMEM_BE_FULL = 4'hF;
  localparam logic       M0           = 1'b0;
  localparam logic       M1           = 1'b1;

  // Lane i comes from wdata when be[i] is set, otherwise from the current word.
  function automatic logic [31:0] be_merge(input logic [31:0] wdata,
                                           input logic [31:0] rdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = rdata;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker; define DMEM_ARB_FIXED_PRIO_EN to make m0 always
// win ties (the rr_last register then disappears).
module dmem_arbiter_rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o,
  output logic       win_o
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
  always_comb begin
    win_o = req_i[0] ? M0 : M1;
  end
`else
  logic rr_last_q;

  // A lone request wins outright; a tie goes to whoever was not granted last.
  always_comb begin
    if (req_i == 2'b11) win_o = ~rr_last_q;
    else if (req_i[1])  win_o = M1;
    else                win_o = M0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         rr_last_q <= M1;
    else if (|gnt_o)    rr_last_q <= win_o;
  end
`endif

  assign gnt_o[0] = en_i & req_i[0] & (win_o == M0);
  assign gnt_o[1] = en_i & req_i[1] & (win_o == M1);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory; partial writes
// become a two-cycle read-modify-write. Optional macro: DMEM_ARB_FIXED_PRIO_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [3:0]    m0_be,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [3:0]    m1_be,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd,
  output state_e        dbg_state_o
);

  // Handshake: a requester holds req and its payload until it sees a one-cycle
  // gnt; a read returns one cycle later as a one-cycle rvalid with rdata.
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);

  state_e        state_q, state_d;
  logic [1:0]    gnt;
  logic          win;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic [3:0]    w_be;
  logic [AW-1:0] rmw_addr_q, rmw_addr_d;
  logic [DW-1:0] merge_q, merge_d;
  logic          rd_go;
  logic [1:0]    rvalid_q;
  logic [DW-1:0] m0_rdata_q, m1_rdata_q;

  dmem_arbiter_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({m1_req, m0_req}),
    .en_i  (state_q == DMEM_ARB_IDLE),
    .gnt_o (gnt),
    .win_o (win)
  );

  always_comb begin
    w_we    = (win == M1) ? m1_we    : m0_we;
    w_addr  = (win == M1) ? m1_addr  : m0_addr;
    w_wdata = (win == M1) ? m1_wdata : m0_wdata;
    w_be    = (win == M1) ? m1_be    : m0_be;
  end

  always_comb begin
    state_d    = state_q;
    rmw_addr_d = rmw_addr_q;
    merge_d    = merge_q;
    rd_go      = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = m0_addr & ALIGN_MASK;
    mem_wd     = merge_q;
    case (state_q)
      DMEM_ARB_IDLE: begin
        if (|gnt) begin
          mem_addr = w_addr & ALIGN_MASK;
          if (!w_we) begin
            rd_go = 1'b1;
          end else if (w_be == DMEM_BE_FULL) begin
            mem_we = 1'b1;
            mem_wd = w_wdata;
          end else if (w_be != 4'h0) begin
            // The grant cycle doubles as the read half of the RMW.
            rmw_addr_d = w_addr & ALIGN_MASK;
            merge_d    = be_merge(w_wdata, mem_rd, w_be);
            state_d    = DMEM_ARB_RMW_WR;
          end
        end
      end
      DMEM_ARB_RMW_WR: begin
        mem_we   = 1'b1;
        mem_addr = rmw_addr_q;
        mem_wd   = merge_q;
        state_d  = DMEM_ARB_IDLE;
      end
      default: state_d = DMEM_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DMEM_ARB_IDLE;
      rmw_addr_q <= '0;
      merge_q    <= '0;
      rvalid_q   <= 2'b00;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      rmw_addr_q <= rmw_addr_d;
      merge_q    <= merge_d;
      rvalid_q   <= {rd_go & (win == M1), rd_go & (win == M0)};
      if (rd_go && win == M0) m0_rdata_q <= mem_rd;
      if (rd_go && win == M1) m1_rdata_q <= mem_rd;
    end
  end

  assign m0_gnt      = gnt[0];
  assign m1_gnt      = gnt[1];
  assign m0_rvalid   = rvalid_q[0];
  assign m1_rvalid   = rvalid_q[1];
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign dbg_state_o = state_q;

endmodule
